serial_word_tx: RTL

Parallel-to-serial transmitter that feeds the serial divisibility-checker path. It accepts a WIDTH-bit word over a valid/ready handshake and emits a one-cycle clear pulse so the downstream checker restarts. It then shifts the word out MSB-first, one bit per clock, with bit_valid and last_bit framing. It also computes the reference "divisible by 3" verdict of the transmitted word in parallel, so benches and system logic can compare it against the downstream serial checker.

---
 rtl/serial_word_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_word_tx.sv
// serial_word_tx
//   Parallel-to-serial transmitter for the serial divisibility-checker path.
//   It accepts one WIDTH-bit word over a valid/ready handshake. It then
//   raises a one-cycle clear pulse so the downstream checker restarts.
//   After that it shifts the word out MSB-first, one bit per clock.
//   While shifting, it works out its own "divisible by 3" verdict for the
//   same word, so the serial checker's answer can be cross-checked.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst         asynchronous active-high reset
//   data_in     word to transmit, sampled only on an accepted load
//   load_valid  producer offers data_in
//   load_ready  block can accept a word this cycle (IDLE or DONE)
//   bit_out     serial data, MSB first, 0 when bit_valid is low
//   bit_valid   bit_out carries a payload bit this cycle
//   last_bit    bit_out is the LSB of the word
//   seq_clr     one-cycle restart pulse for the downstream checker
//   done        one-cycle pulse in the cycle after the final bit
//   div3        1 if the last transmitted word is a multiple of 3
module serial_word_tx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             seq_clr,
  output logic             done,
  output logic             div3
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       rem;
  logic [1:0]       rem_next;
  logic             div3_q;
  logic             accept;
  logic             cnt_zero;

  // All outputs are decoded from the registered state and the datapath
  // registers only, so no input has a combinational path to an output.
  assign load_ready = (state == IDLE) || (state == DONE);
  assign seq_clr    = (state == CLEAR);
  assign bit_valid  = (state == SHIFT);
  assign bit_out    = (state == SHIFT) && shreg[WIDTH-1];
  assign cnt_zero   = (cnt == '0);
  assign last_bit   = (state == SHIFT) && cnt_zero;
  assign done       = (state == DONE);
  assign div3       = div3_q;
  assign accept     = load_valid && load_ready;

  // Remainder of the running prefix modulo 3. Appending a bit b to a
  // prefix with remainder r gives (2r + b) mod 3. Code 3 cannot be reached.
  always_comb begin
    rem_next = 2'd0;
    case ({rem, bit_out})
      3'b00_0: rem_next = 2'd0;
      3'b00_1: rem_next = 2'd1;
      3'b01_0: rem_next = 2'd2;
      3'b01_1: rem_next = 2'd0;
      3'b10_0: rem_next = 2'd1;
      3'b10_1: rem_next = 2'd2;
      default: rem_next = 2'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. An accept in DONE goes straight to CLEAR so that
  // words can run back to back, one every WIDTH+2 cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CLEAR;
      CLEAR:   state_next = SHIFT;
      SHIFT:   if (cnt_zero) state_next = DONE;
      DONE:    state_next = accept ? CLEAR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. data_in is captured only on an accept, so any traffic on the
  // load side during CLEAR/SHIFT cannot disturb the word in flight. div3
  // changes only when the final bit is consumed, so it holds through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      cnt    <= '0;
      rem    <= 2'd0;
      div3_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            shreg <= data_in;
            cnt   <= CNT_MAX;
          end
        end
        CLEAR: begin
          rem <= 2'd0;
        end
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          cnt   <= cnt - CNT_W'(1);
          rem   <= rem_next;
          if (cnt_zero) begin
            div3_q <= (rem_next == 2'd0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
